// File: rtl/tank_sprite_arbiter.sv
// Per-pixel arbiter sharing one 32x32 sprite ROM and one palette among N_SPR tank sprites.
// Heading-rotated ROM addressing, transparency, registered RGB and per-frame overlap flags.
module tank_sprite_arbiter #(
  parameter int          N_SPR   = 4,
  parameter logic [9:0]  V_LATCH = 10'd480,
  parameter logic [3:0]  TRANSP  = 4'h0,
  parameter logic [11:0] BG_RGB  = 12'h000
) (
  input  logic                vga_clk,
  input  logic                Reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic [10*N_SPR-1:0] spr_x_in,
  input  logic [10*N_SPR-1:0] spr_y_in,
  input  logic [2*N_SPR-1:0]  spr_dir_in,
  input  logic [N_SPR-1:0]    spr_en_in,
  output logic [9:0]          rom_address,
  input  logic [3:0]          rom_q,
  output logic [3:0]          pal_index,
  input  logic [3:0]          palette_red,
  input  logic [3:0]          palette_green,
  input  logic [3:0]          palette_blue,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic [N_SPR-1:0]    coll_mask,
  output logic                frame_tick
);

  localparam int WIN_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  logic [10*N_SPR-1:0] act_x_r;
  logic [10*N_SPR-1:0] act_y_r;
  logic [2*N_SPR-1:0]  act_dir_r;
  logic [N_SPR-1:0]    act_en_r;

  logic [N_SPR-1:0]    hit_s;
  logic [WIN_W-1:0]    win_s;
  logic [4:0]          r_s;
  logic [4:0]          c_s;
  logic [1:0]          dir_s;
  logic [9:0]          addr_s;
  logic                tick_s;
  logic                multi_s;
  logic [11:0]         rgb_s;

  logic                hit_d1_r;
  logic                hit_d2_r;
  logic                blank_d1_r;
  logic                blank_d2_r;
  logic [N_SPR-1:0]    coll_acc_r;

  assign tick_s    = (DrawX == 10'd0) && (DrawY == V_LATCH);
  assign pal_index = rom_q;
  // Two or more bits set: clearing the lowest set bit still leaves something.
  assign multi_s   = |(hit_s & (hit_s - N_SPR'(1)));

  // Box test against the frame-stable sprite set; 11-bit sums so edge sprites clip instead of wrapping.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit_s[i] = act_en_r[i]
        && ({1'b0, DrawX} >= {1'b0, act_x_r[10*i +: 10]})
        && ({1'b0, DrawX} <  ({1'b0, act_x_r[10*i +: 10]} + 11'd32))
        && ({1'b0, DrawY} >= {1'b0, act_y_r[10*i +: 10]})
        && ({1'b0, DrawY} <  ({1'b0, act_y_r[10*i +: 10]} + 11'd32));
    end
  end

  // Priority pick: scanning downward lets the lowest hitting index overwrite the rest.
  always_comb begin
    win_s = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      win_s = hit_s[i] ? WIN_W'(i) : win_s;
    end
  end

  // Winner-relative row/column and heading-rotated ROM address.
  always_comb begin
    r_s   = 5'(DrawY - act_y_r[10*win_s +: 10]);
    c_s   = 5'(DrawX - act_x_r[10*win_s +: 10]);
    dir_s = act_dir_r[2*win_s +: 2];
    case (dir_s)
      2'b00:   addr_s = {r_s, c_s};
      2'b01:   addr_s = {~c_s, r_s};
      2'b10:   addr_s = {~r_s, ~c_s};
      2'b11:   addr_s = {c_s, ~r_s};
      default: addr_s = {r_s, c_s};
    endcase
  end

  // Shadow sprite set reloads only on the frame-boundary pixel.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      act_x_r   <= '0;
      act_y_r   <= '0;
      act_dir_r <= '0;
      act_en_r  <= '0;
    end else if (tick_s) begin
      act_x_r   <= spr_x_in;
      act_y_r   <= spr_y_in;
      act_dir_r <= spr_dir_in;
      act_en_r  <= spr_en_in;
    end
  end

  // Address stage and hit/blank delay line matching the ROM read latency.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_address <= 10'd0;
      hit_d1_r    <= 1'b0;
      hit_d2_r    <= 1'b0;
      blank_d1_r  <= 1'b0;
      blank_d2_r  <= 1'b0;
    end else begin
      if (|hit_s) begin
        rom_address <= addr_s;
      end
      hit_d1_r   <= |hit_s;
      blank_d1_r <= blank;
      hit_d2_r   <= hit_d1_r;
      blank_d2_r <= blank_d1_r;
    end
  end

  // Final colour: blanking forces black; a transparent winner texel shows background only.
  always_comb begin
    if (!blank_d2_r) begin
      rgb_s = 12'h000;
    end else if (hit_d2_r && (rom_q != TRANSP)) begin
      rgb_s = {palette_red, palette_green, palette_blue};
    end else begin
      rgb_s = BG_RGB;
    end
  end

  // Registered pixel colour.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      {red, green, blue} <= 12'h000;
    end else begin
      {red, green, blue} <= rgb_s;
    end
  end

  // Overlap accumulation over visible pixels, published and cleared at the frame boundary.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      coll_acc_r <= '0;
      coll_mask  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick_s;
      if (tick_s) begin
        coll_mask  <= coll_acc_r;
        coll_acc_r <= '0;
      end else if (blank && multi_s) begin
        coll_acc_r <= coll_acc_r | hit_s;
      end
    end
  end

endmodule
